// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: clock divider controller; ratio changes take effect only at period boundaries
module freq_div_ctrl #(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = 4,
  parameter int PCNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic              clockout,
  output logic              tick,
  output logic              busy,
  output logic [PCNT_W-1:0] period_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, half_q, half_d, pend_q, pend_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic clk_q, clk_d, tick_q, tick_d, err_q, err_d, busy_q, busy_d, rdy_q, rdy_d;
  logic acc, load, counting, hit, tog, fall, has_p, apply, going_idle;
  assign acc      = cfg_valid && rdy_q;
  assign load     = state_q == RUN && acc && cfg_half != '0;
  assign counting = state_q != IDLE;
  assign hit      = cnt_q == half_q - CNT_W'(1);
  assign tog      = counting && hit;
  assign fall     = tog && clk_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= CNT_W'(DEFAULT_HALF);
      pend_q  <= '0;
      pcnt_q  <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      pend_q  <= pend_d;
      pcnt_q  <= pcnt_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end
  // Dropping en while high lets the high phase finish in STOP so no runt pulse appears
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = en ? RUN : IDLE;
      RUN, PEND: state_d = !en ? ((!clk_q || fall) ? IDLE : STOP)
                               : (state_q == PEND && fall) ? RUN : load ? PEND : state_q;
      STOP:      state_d = fall ? IDLE : STOP;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    going_idle = state_d == IDLE;
    has_p      = busy_q || load;
    apply      = (busy_q && fall) || (has_p && counting && going_idle);
    pend_d     = load ? cfg_half : pend_q;
    half_d     = apply ? pend_d : (state_q == IDLE && acc && cfg_half != '0) ? cfg_half : half_q;
    busy_d     = has_p && !apply;
    cnt_d      = (!counting || going_idle || hit) ? '0 : cnt_q + CNT_W'(1);
    clk_d      = !going_idle && (clk_q ^ tog);
    tick_d     = !going_idle && tog && !clk_q;
    pcnt_d     = pcnt_q + PCNT_W'(fall);
    err_d      = acc && cfg_half == '0;
    rdy_d      = state_d == IDLE || state_d == RUN;
  end
  assign cfg_ready  = rdy_q;
  assign cfg_err    = err_q;
  assign clockout   = clk_q;
  assign tick       = tick_q;
  assign busy       = busy_q;
  assign period_cnt = pcnt_q;
endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb_freq_div_ctrl: directed scenario tests for freq_div_ctrl with hand-derived waveforms
module tb_freq_div_ctrl;
  logic clk = 1'b0;
  logic rst, en, cfg_valid;
  logic [7:0] cfg_half;
  logic cfg_ready, cfg_err, clockout, tick, busy;
  logic [15:0] period_cnt;
  logic [17:0] e;
  int n_cmp = 0;
  int n_fail = 0;

  freq_div_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_half(cfg_half),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clockout(clockout), .tick(tick),
    .busy(busy), .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    step(3);
    n_cmp++; if ({clockout, tick, cfg_err, busy, cfg_ready, period_cnt} !== {5'b00001, 16'd0}) begin
      n_fail++; $display("FAIL reset: got %h want %h", {clockout, tick, cfg_err, busy, cfg_ready, period_cnt}, {5'b00001, 16'd0}); end
    rst = 1'b0;
    step(2);
    n_cmp++; if ({clockout, cfg_ready, period_cnt} !== {2'b01, 16'd0}) begin
      n_fail++; $display("FAIL reset_idle: got %h want %h", {clockout, cfg_ready, period_cnt}, {2'b01, 16'd0}); end
  endtask

  task automatic test_default();
    do_reset();
    en = 1'b1;
    step();
    for (int r = 1; r <= 24; r++) begin
      step();
      e = {((r / 4) % 2) == 1, (r % 8) == 4, 16'(r / 8)};
      n_cmp++; if ({clockout, tick, period_cnt} !== e) begin
        n_fail++; $display("FAIL default r=%0d: got %h want %h", r, {clockout, tick, period_cnt}, e); end
    end
  endtask

  task automatic test_change();
    do_reset();
    en = 1'b1;
    step(6);
    cfg_valid = 1'b1; cfg_half = 8'd2;
    step();
    cfg_valid = 1'b0;
    n_cmp++; if ({busy, cfg_ready, clockout} !== 3'b101) begin
      n_fail++; $display("FAIL change_accept: got %b want 101", {busy, cfg_ready, clockout}); end
    step();
    n_cmp++; if ({busy, cfg_ready, clockout} !== 3'b101) begin
      n_fail++; $display("FAIL change_hold: got %b want 101", {busy, cfg_ready, clockout}); end
    step();
    n_cmp++; if ({busy, cfg_ready, clockout, period_cnt} !== {3'b010, 16'd1}) begin
      n_fail++; $display("FAIL change_apply: got %h want %h", {busy, cfg_ready, clockout, period_cnt}, {3'b010, 16'd1}); end
    for (int r = 9; r <= 16; r++) begin
      step();
      e = {(((r - 8) / 2) % 2) == 1, ((r - 8) % 4) == 2, 16'(1 + (r - 8) / 4)};
      n_cmp++; if ({clockout, tick, period_cnt} !== e) begin
        n_fail++; $display("FAIL change_h2 r=%0d: got %h want %h", r, {clockout, tick, period_cnt}, e); end
    end
  endtask

  task automatic test_err();
    do_reset();
    cfg_valid = 1'b1; cfg_half = 8'd0;
    step();
    cfg_valid = 1'b0;
    n_cmp++; if ({cfg_err, cfg_ready} !== 2'b11) begin
      n_fail++; $display("FAIL err_idle: got %b want 11", {cfg_err, cfg_ready}); end
    step();
    n_cmp++; if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL err_idle_pulse: got %b want 0", cfg_err); end
    en = 1'b1;
    step(3);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    n_cmp++; if ({cfg_err, busy, cfg_ready} !== 3'b101) begin
      n_fail++; $display("FAIL err_run: got %b want 101", {cfg_err, busy, cfg_ready}); end
    step();
    n_cmp++; if ({cfg_err, clockout, tick} !== 3'b011) begin
      n_fail++; $display("FAIL err_run_pulse: got %b want 011", {cfg_err, clockout, tick}); end
    for (int r = 5; r <= 16; r++) begin
      step();
      e = {((r / 4) % 2) == 1, (r % 8) == 4, 16'(r / 8)};
      n_cmp++; if ({clockout, tick, period_cnt} !== e) begin
        n_fail++; $display("FAIL err_ratio r=%0d: got %h want %h", r, {clockout, tick, period_cnt}, e); end
    end
  endtask

  task automatic test_stop();
    do_reset();
    en = 1'b1;
    step(6);
    en = 1'b0;
    step();
    n_cmp++; if ({clockout, cfg_ready, busy} !== 3'b100) begin
      n_fail++; $display("FAIL stop_enter: got %b want 100", {clockout, cfg_ready, busy}); end
    en = 1'b1;
    step();
    n_cmp++; if (clockout !== 1'b1) begin
      n_fail++; $display("FAIL stop_high: got %b want 1", clockout); end
    step();
    n_cmp++; if ({clockout, cfg_ready, period_cnt} !== {2'b01, 16'd1}) begin
      n_fail++; $display("FAIL stop_fall: got %h want %h", {clockout, cfg_ready, period_cnt}, {2'b01, 16'd1}); end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if ({clockout, period_cnt} !== {1'b0, 16'd1}) begin
        n_fail++; $display("FAIL stop_idle i=%0d: got %h want %h", i, {clockout, period_cnt}, {1'b0, 16'd1}); end
    end
    en = 1'b1;
    step(3);
    en = 1'b0;
    step();
    n_cmp++; if ({clockout, cfg_ready, period_cnt} !== {2'b01, 16'd1}) begin
      n_fail++; $display("FAIL low_drop: got %h want %h", {clockout, cfg_ready, period_cnt}, {2'b01, 16'd1}); end
    step(3);
    n_cmp++; if ({clockout, period_cnt} !== {1'b0, 16'd1}) begin
      n_fail++; $display("FAIL low_drop_idle: got %h want %h", {clockout, period_cnt}, {1'b0, 16'd1}); end
  endtask

  task automatic test_h1();
    do_reset();
    cfg_valid = 1'b1; cfg_half = 8'd1;
    step();
    cfg_valid = 1'b0; en = 1'b1;
    step();
    for (int r = 1; r <= 8; r++) begin
      step();
      e = {(r % 2) == 1, (r % 2) == 1, 16'(r / 2)};
      n_cmp++; if ({clockout, tick, period_cnt} !== e) begin
        n_fail++; $display("FAIL h1 r=%0d: got %h want %h", r, {clockout, tick, period_cnt}, e); end
    end
  endtask

  task automatic test_hmax();
    do_reset();
    cfg_valid = 1'b1; cfg_half = 8'd255;
    step();
    cfg_valid = 1'b0; en = 1'b1;
    step();
    step(254);
    n_cmp++; if ({clockout, tick} !== 2'b00) begin
      n_fail++; $display("FAIL hmax_low_end: got %b want 00", {clockout, tick}); end
    step();
    n_cmp++; if ({clockout, tick} !== 2'b11) begin
      n_fail++; $display("FAIL hmax_rise: got %b want 11", {clockout, tick}); end
    step();
    n_cmp++; if ({clockout, tick} !== 2'b10) begin
      n_fail++; $display("FAIL hmax_tick_once: got %b want 10", {clockout, tick}); end
    step(253);
    n_cmp++; if ({clockout, period_cnt} !== {1'b1, 16'd0}) begin
      n_fail++; $display("FAIL hmax_high_end: got %h want %h", {clockout, period_cnt}, {1'b1, 16'd0}); end
    step();
    n_cmp++; if ({clockout, period_cnt} !== {1'b0, 16'd1}) begin
      n_fail++; $display("FAIL hmax_fall: got %h want %h", {clockout, period_cnt}, {1'b0, 16'd1}); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    en = 1'b1;
    step(6);
    cfg_valid = 1'b1; cfg_half = 8'd2;
    step();
    cfg_valid = 1'b0;
    n_cmp++; if ({busy, clockout} !== 2'b11) begin
      n_fail++; $display("FAIL rst_mid_pending: got %b want 11", {busy, clockout}); end
    step();
    rst = 1'b1;
    #1;
    n_cmp++; if ({clockout, tick, cfg_err, busy, cfg_ready, period_cnt} !== {5'b00001, 16'd0}) begin
      n_fail++; $display("FAIL rst_mid_async: got %h want %h", {clockout, tick, cfg_err, busy, cfg_ready, period_cnt}, {5'b00001, 16'd0}); end
    step();
    rst = 1'b0;
    step();
    step(2);
    n_cmp++; if (clockout !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_h4_low: got %b want 0", clockout); end
    step(2);
    n_cmp++; if ({clockout, tick} !== 2'b11) begin
      n_fail++; $display("FAIL rst_mid_h4_rise: got %b want 11", {clockout, tick}); end
    step(4);
    n_cmp++; if ({clockout, busy, period_cnt} !== {2'b00, 16'd1}) begin
      n_fail++; $display("FAIL rst_mid_h4_fall: got %h want %h", {clockout, busy, period_cnt}, {2'b00, 16'd1}); end
  endtask

  initial begin
    test_reset();
    test_default();
    test_change();
    test_err();
    test_stop();
    test_h1();
    test_hmax();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
